jtag_host_ctrl: RTL and testbench

Host-side JTAG master for the debug path. It accepts IR-scan, DR-scan, reset and idle commands on a valid/ready interface. It generates TCK from the system clock and drives TMS/TDI, and samples TDO, so that a RISC-V DTM TAP (IDCODE, DTMCS, DMI access) can be exercised from on-chip logic or a bench. Captured TDO bits are returned as one response per command.

---
 rtl/jtag_host_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_jtag_host_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_host_ctrl.sv
// Purpose: host-side JTAG master; runs TAP reset, IR/DR scan and idle commands, returns captured TDO.
// Latency: N*2*ClkDiv+1 clk_i cycles from command handshake to rsp_valid_o (N = TCK cycles for the op).
// Backpressure: one command in flight; cmd_ready_o low until the response is taken, TCK parked low meanwhile.
// Ports: cmd_* command channel (valid/ready), rsp_* response channel (valid/ready),
//        tck_o/tms_o/tdi_o/tdo_i/trst_no JTAG pins. clk_i is the only clock, rst_ni async active-low.
module jtag_host_ctrl #(
    parameter int MaxLen = 64,
    parameter int ClkDiv = 2,
    parameter int LenW   = $clog2(MaxLen + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [LenW-1:0]   cmd_len_i,
    input  logic [MaxLen-1:0] cmd_data_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [MaxLen-1:0] rsp_data_o,
    output logic              tck_o,
    output logic              tms_o,
    output logic              tdi_o,
    input  logic              tdo_i,
    output logic              trst_no
);
    // One extra bit so the longest op (MaxLen+6 steps) still fits.
    localparam int StepW = LenW + 1;
    localparam int CntW  = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;

    localparam logic [1:0] OpReset = 2'd0;
    localparam logic [1:0] OpIr    = 2'd1;
    localparam logic [1:0] OpDr    = 2'd2;

    typedef enum logic [1:0] {StIdle, StLow, StHigh, StResp} state_t;
    state_t state_q, state_d;

    logic              trst_q;
    logic [1:0]        op_q;
    logic [LenW-1:0]   len_q;
    logic [MaxLen-1:0] data_q;
    logic [MaxLen-1:0] cap_q;
    logic [StepW-1:0]  step_q;
    logic [StepW-1:0]  nsteps_q;
    logic [CntW-1:0]   cnt_q;
    logic              shift_q;
    logic [LenW-1:0]   idx_q;
    logic              tck_q, tms_q, tdi_q;

    logic [LenW-1:0]   len_eff;
    logic [StepW-1:0]  nsteps_in;
    logic              div_done;

    assign len_eff  = (cmd_len_i > LenW'(MaxLen)) ? LenW'(MaxLen) : cmd_len_i;
    assign div_done = (cnt_q == CntW'(ClkDiv - 1));

    always_comb begin
        case (cmd_op_i)
            OpReset: nsteps_in = StepW'(6);
            OpIr:    nsteps_in = StepW'(len_eff) + StepW'(6);
            OpDr:    nsteps_in = StepW'(len_eff) + StepW'(5);
            default: nsteps_in = StepW'(len_eff);
        endcase
    end

    // Decode of the step about to be driven on the next falling TCK edge.
    // From IDLE that is step 0 of the incoming command, otherwise step_q+1.
    logic [1:0]        dec_op;
    logic [LenW-1:0]   dec_len;
    logic [MaxLen-1:0] dec_data;
    logic [StepW-1:0]  dec_step, pre, rel;
    logic              dec_tms, dec_tdi, dec_shift;
    logic [LenW-1:0]   dec_idx;

    always_comb begin
        if (state_q == StIdle) begin
            dec_op   = cmd_op_i;
            dec_len  = len_eff;
            dec_data = cmd_data_i;
            dec_step = '0;
        end else begin
            dec_op   = op_q;
            dec_len  = len_q;
            dec_data = data_q;
            dec_step = step_q + StepW'(1);
        end
        // IR path walks Select-DR, Select-IR, Capture, Shift; DR path skips Select-IR.
        pre       = (dec_op == OpIr) ? StepW'(4) : StepW'(3);
        rel       = dec_step - pre;
        dec_idx   = rel[LenW-1:0];
        dec_tms   = 1'b0;
        dec_tdi   = 1'b0;
        dec_shift = 1'b0;
        case (dec_op)
            OpReset: dec_tms = (dec_step < StepW'(5));
            OpIr, OpDr: begin
                if (dec_step < pre) begin
                    dec_tms = (dec_op == OpIr) ? (dec_step < StepW'(2)) : (dec_step == '0);
                end else if (rel < StepW'(dec_len)) begin
                    dec_shift = 1'b1;
                    dec_tdi   = |(dec_data & (MaxLen'(1) << dec_idx));
                    dec_tms   = (rel == StepW'(dec_len) - StepW'(1));
                end else begin
                    // Exit1 -> Update on the first post-shift cycle, then back to Run-Test/Idle.
                    dec_tms = (rel == StepW'(dec_len));
                end
            end
            default: dec_tms = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (cmd_valid_i && trst_q) begin
                    state_d = (cmd_op_i != OpReset && len_eff == '0) ? StResp : StLow;
                end
            end
            StLow:  if (div_done) state_d = StHigh;
            StHigh: begin
                if (div_done) begin
                    state_d = (step_q == nsteps_q - StepW'(1)) ? StResp : StLow;
                end
            end
            default: if (rsp_ready_i) state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trst_q   <= 1'b0;
            op_q     <= '0;
            len_q    <= '0;
            data_q   <= '0;
            cap_q    <= '0;
            step_q   <= '0;
            nsteps_q <= '0;
            cnt_q    <= '0;
            shift_q  <= 1'b0;
            idx_q    <= '0;
            tck_q    <= 1'b0;
            tms_q    <= 1'b0;
            tdi_q    <= 1'b0;
        end else begin
            trst_q <= 1'b1;
            // Half-period counter restarts on every phase change.
            cnt_q  <= (state_d != state_q) ? '0 : cnt_q + CntW'(1);

            if (state_q == StIdle && state_d != StIdle) begin
                op_q     <= cmd_op_i;
                len_q    <= len_eff;
                data_q   <= cmd_data_i;
                nsteps_q <= nsteps_in;
                cap_q    <= '0;
                step_q   <= '0;
            end

            // Falling TCK: TMS/TDI only ever change here.
            if (state_d == StLow && state_q != StLow) begin
                tck_q   <= 1'b0;
                tms_q   <= dec_tms;
                tdi_q   <= dec_tdi;
                shift_q <= dec_shift;
                idx_q   <= dec_idx;
                if (state_q == StHigh) step_q <= step_q + StepW'(1);
            end

            // Rising TCK: TDO was launched half a period earlier, sample it now.
            if (state_d == StHigh && state_q == StLow) begin
                tck_q <= 1'b1;
                if (shift_q) cap_q <= cap_q | (MaxLen'(tdo_i) << idx_q);
            end

            if (state_q == StHigh && state_d == StResp) begin
                tck_q <= 1'b0;
                tdi_q <= 1'b0;
            end
        end
    end

    assign cmd_ready_o = (state_q == StIdle) && trst_q;
    assign rsp_valid_o = (state_q == StResp);
    assign rsp_data_o  = cap_q;
    assign tck_o       = tck_q;
    assign tms_o       = tms_q;
    assign tdi_o       = tdi_q;
    assign trst_no     = trst_q;

endmodule

// File: tb/tb_jtag_host_ctrl.sv
// Bench for jtag_host_ctrl: drives commands into the host, attaches a small RISC-V DTM TAP
// (IDCODE / DTMCS / DMI / BYPASS) on the pins, and scores every response against a reference model.
module tb_jtag_host_ctrl;
    localparam int MaxLen = 64;
    localparam int ClkDiv = 1;
    localparam int LenW   = $clog2(MaxLen + 1);

    localparam logic [4:0] IrIdcode = 5'h01;
    localparam logic [4:0] IrDtmcs  = 5'h10;
    localparam logic [4:0] IrDmi    = 5'h11;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = '0;
    logic [LenW-1:0]   cmd_len = '0;
    logic [MaxLen-1:0] cmd_data = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [MaxLen-1:0] rsp_data;
    logic              tck, tms, tdi, trst_n;
    logic              tdo = 1'b0;

    always #5 clk = ~clk;

    jtag_host_ctrl #(.MaxLen(MaxLen), .ClkDiv(ClkDiv), .LenW(LenW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
        .cmd_len_i(cmd_len), .cmd_data_i(cmd_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .tck_o(tck), .tms_o(tms), .tdi_o(tdi), .tdo_i(tdo), .trst_no(trst_n)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Register table of the attached DTM.
    function automatic int dr_width(input logic [4:0] ir);
        case (ir)
            IrIdcode, IrDtmcs: return 32;
            IrDmi:             return 41;
            default:           return 1;
        endcase
    endfunction

    function automatic logic [63:0] dr_capture(input logic [4:0] ir, input logic [40:0] dmi);
        case (ir)
            IrIdcode: return 64'h1;
            IrDtmcs:  return 64'h5071;
            IrDmi:    return {23'd0, dmi};
            default:  return 64'h0;
        endcase
    endfunction

    // ---------------- TAP device on the pins ----------------
    typedef enum int {T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PAUDR, T_EX2DR, T_UPDDR,
                      T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PAUIR, T_EX2IR, T_UPDIR} tap_t;
    tap_t        tap_st;
    logic [4:0]  tap_ir;
    logic [40:0] tap_dmi;
    logic [63:0] tap_sr;
    int          tap_w;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            T_TLR:   return m ? T_TLR   : T_RTI;
            T_RTI:   return m ? T_SELDR : T_RTI;
            T_SELDR: return m ? T_SELIR : T_CAPDR;
            T_CAPDR: return m ? T_EX1DR : T_SHDR;
            T_SHDR:  return m ? T_EX1DR : T_SHDR;
            T_EX1DR: return m ? T_UPDDR : T_PAUDR;
            T_PAUDR: return m ? T_EX2DR : T_PAUDR;
            T_EX2DR: return m ? T_UPDDR : T_SHDR;
            T_UPDDR: return m ? T_SELDR : T_RTI;
            T_SELIR: return m ? T_TLR   : T_CAPIR;
            T_CAPIR: return m ? T_EX1IR : T_SHIR;
            T_SHIR:  return m ? T_EX1IR : T_SHIR;
            T_EX1IR: return m ? T_UPDIR : T_PAUIR;
            T_PAUIR: return m ? T_EX2IR : T_PAUIR;
            T_EX2IR: return m ? T_UPDIR : T_SHIR;
            default: return m ? T_SELDR : T_RTI;
        endcase
    endfunction

    always @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            tap_st  <= T_RTI;
            tap_ir  <= IrIdcode;
            tap_dmi <= '0;
            tap_sr  <= '0;
            tap_w   <= 1;
        end else begin
            case (tap_st)
                T_TLR:   tap_ir <= IrIdcode;
                T_CAPIR: begin tap_sr <= 64'h05; tap_w <= 5; end
                T_CAPDR: begin tap_sr <= dr_capture(tap_ir, tap_dmi); tap_w <= dr_width(tap_ir); end
                T_SHIR, T_SHDR: tap_sr <= (tap_sr >> 1) | (64'(tdi) << (tap_w - 1));
                T_UPDIR: tap_ir <= tap_sr[4:0];
                T_UPDDR: if (tap_ir == IrDmi) tap_dmi <= tap_sr[40:0];
                default: ;
            endcase
            tap_st <= tap_next(tap_st, tms);
        end
    end

    always @(negedge tck or negedge trst_n) begin
        if (!trst_n) tdo <= 1'b0;
        else tdo <= (tap_st == T_SHIR || tap_st == T_SHDR) ? tap_sr[0] : 1'b0;
    end

    // ---------------- Reference model + scoreboard ----------------
    typedef struct {
        logic [63:0]  rsp;
        int           ntck;
        logic [127:0] tmsv;
        logic [127:0] tdiv;
        int           lat;
    } exp_t;

    exp_t        sbq[$];
    logic [4:0]  ref_ir = IrIdcode;
    logic [40:0] ref_dmi = '0;
    int          n_sent = 0;
    int          n_rsp = 0;

    // A scan pushes {data, capture} through a W-bit register: TDO is the low L bits of
    // that stream and the register keeps the next W bits.
    task automatic predict(input int op, input int len, input logic [63:0] data);
        exp_t e;
        int l, w, k, pre;
        logic [127:0] x, nv, mask;
        l = (len > MaxLen) ? MaxLen : len;
        e.rsp = '0; e.tmsv = '0; e.tdiv = '0; k = 0;
        if (op == 0) begin
            for (int i = 0; i < 6; i++) e.tmsv[i] = (i < 5);
            k = 6;
            ref_ir = IrIdcode;
        end else if (op == 3) begin
            k = l;
        end else if (l > 0) begin
            pre = (op == 1) ? 4 : 3;
            e.tmsv[0] = 1'b1;
            if (op == 1) e.tmsv[1] = 1'b1;
            for (int i = 0; i < l; i++) begin
                e.tdiv[pre+i] = data[i];
                e.tmsv[pre+i] = (i == l - 1);
            end
            e.tmsv[pre+l] = 1'b1;
            k = pre + l + 2;
            w = (op == 1) ? 5 : dr_width(ref_ir);
            mask = (128'(1) << l) - 128'(1);
            x = ((128'(data) & mask) << w) | ((op == 1) ? 128'h5 : 128'(dr_capture(ref_ir, ref_dmi)));
            e.rsp = 64'(x & mask);
            nv = x >> l;
            if (op == 1) ref_ir = nv[4:0];
            else if (ref_ir == IrDmi) ref_dmi = nv[40:0];
        end
        e.ntck = k;
        e.lat  = 2 * k * ClkDiv + 1;
        sbq.push_back(e);
    endtask

    // ---------------- Monitor ----------------
    int           cyc = 0;
    int           hs_cyc = 0;
    int           ntck = 0;
    logic [127:0] tms_log = '0;
    logic [127:0] tdi_log = '0;
    logic         tck_prev = 1'b0;
    logic         in_rsp = 1'b0;
    logic         bad = 1'b0;
    logic [63:0]  held = '0;
    exp_t         me;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            in_rsp = 1'b0;
            ntck   = 0;
        end else begin
            if (tck && !tck_prev && ntck < 128) begin
                tms_log[ntck] = tms;
                tdi_log[ntck] = tdi;
                ntck++;
            end
            if (rsp_valid) begin
                if (!in_rsp) begin
                    in_rsp = 1'b1;
                    held   = rsp_data;
                    bad    = 1'b0;
                    check("rsp_expected", sbq.size() != 0, 1);
                    if (sbq.size() != 0) begin
                        me = sbq.pop_front();
                        check("rsp_data", rsp_data, me.rsp);
                        check("tck_count", ntck, me.ntck);
                        check("tms_seq", tms_log, me.tmsv);
                        check("tdi_seq", tdi_log, me.tdiv);
                        check("latency", cyc - hs_cyc, me.lat);
                    end
                end
                if (rsp_data !== held || cmd_ready || tck) bad = 1'b1;
                if (rsp_ready) begin
                    check("rsp_hold", bad, 0);
                    in_rsp = 1'b0;
                    n_rsp++;
                end
            end
            if (cmd_valid && cmd_ready) begin
                hs_cyc  = cyc;
                ntck    = 0;
                tms_log = '0;
                tdi_log = '0;
            end
        end
        tck_prev = tck;
    end

    // ---------------- Drivers ----------------
    logic bp_mode = 1'b0;

    initial forever begin
        @(posedge clk);
        #1;
        if (!bp_mode) rsp_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input int op, input int len, input logic [63:0] data);
        int t;
        @(posedge clk);
        #1;
        predict(op, len, data);
        n_sent++;
        cmd_op    = 2'(op);
        cmd_len   = LenW'(len);
        cmd_data  = data;
        cmd_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("cmd_accept_in_time", t < 5000, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((sbq.size() != 0 || !cmd_ready) && t < 5000);
        check("rsp_in_time", t < 5000, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int t, rsp_before, op, len;
        logic [63:0] data;

        // Reset and release.
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {cmd_ready, rsp_valid, tck, tms, tdi, trst_n, |rsp_data}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_before_edge", {trst_n, cmd_ready}, 2'b00);
        @(posedge clk);
        #1;
        check("release_after_edge", {trst_n, cmd_ready, rsp_valid, tck}, 4'b1100);

        // TAP reset, IR=DTMCS scan, IDCODE read.
        send(0, 0, 64'h0);
        wait_done();
        check("tap_ir_after_reset", tap_ir, IrIdcode);
        send(1, 5, 64'h10);
        wait_done();
        check("ir_capture", rsp_data, 64'h05);
        check("tap_ir_dtmcs", tap_ir, IrDtmcs);
        send(1, 5, 64'h01);
        send(2, 32, 64'h0);
        wait_done();
        check("idcode_read", rsp_data, 64'h1);

        // Response backpressure.
        bp_mode = 1'b1;
        rsp_ready = 1'b0;
        send(2, 32, {$urandom, $urandom});
        t = 0;
        while (!rsp_valid && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("bp_rsp_seen", rsp_valid, 1);
        repeat (20) @(posedge clk);
        #1;
        check("bp_still_waiting", {rsp_valid, cmd_ready, tck}, 3'b100);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bp_mode = 1'b0;
        wait_done();

        // Boundaries: zero length and over-long length.
        send(2, 0, {$urandom, $urandom});
        send(3, 0, 64'h0);
        send(2, MaxLen + 5, {$urandom, $urandom});
        wait_done();

        // Randomised command stream.
        for (int n = 0; n < 40; n++) begin
            op   = $urandom_range(0, 3);
            data = {$urandom, $urandom};
            case (op)
                1: begin
                    len = $urandom_range(0, 12);
                    if ($urandom_range(0, 1) == 1) begin
                        len = 5;
                        case ($urandom_range(0, 2))
                            0: data = 64'(IrIdcode);
                            1: data = 64'(IrDtmcs);
                            default: data = 64'(IrDmi);
                        endcase
                    end
                end
                2: len = $urandom_range(0, MaxLen + 6);
                3: len = $urandom_range(0, 8);
                default: len = $urandom_range(0, 127);
            endcase
            send(op, len, data);
        end
        wait_done();

        // Reset in the middle of a shift: no response, outputs back to reset values.
        rsp_before = n_rsp;
        send(2, 40, {$urandom, $urandom});
        repeat (30) @(posedge clk);
        #2;
        rst_n = 1'b0;
        sbq.delete();
        n_sent--;
        ref_ir  = IrIdcode;
        ref_dmi = '0;
        #1;
        check("abort_outputs", {cmd_ready, rsp_valid, tck, tms, tdi, trst_n, |rsp_data}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_release", {trst_n, cmd_ready, rsp_valid}, 3'b110);
        repeat (20) @(posedge clk);
        check("no_rsp_after_abort", n_rsp, rsp_before);

        // Host and TAP are both usable again after the abort.
        send(2, 32, 64'h0);
        wait_done();
        check("idcode_after_abort", rsp_data, 64'h1);
        check("rsp_count", n_rsp, n_sent);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
